serial_pattern_detector: RTL and testbench

SERIAL_PATTERN_DETECTOR -- requirements
Module: serial_pattern_detector

---
 rtl/serial_pattern_detector_pkg.sv | 16 +
 rtl/serial_pattern_detector.sv | 92 +++++++++
 tb/tb_serial_pattern_detector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_detector_pkg
// Shared constants for the serial pattern detector and the downstream
// per-second hit counter that consumes its o_hit pulse.
//   DEF_PAT_W    : default pattern length in bits
//   DEF_PATTERN  : default target sequence (ASCII "HB"), MSB received first,
//                  zero-extended to 32 bits so any PAT_W up to 32 can slice it
//   HIT_CNT_W    : width of the downstream hit counter
// -----------------------------------------------------------------------------
package serial_pattern_detector_pkg;

   localparam int unsigned DEF_PAT_W   = 16;
   localparam logic [31:0] DEF_PATTERN = 32'h0000_4842;
   localparam int unsigned HIT_CNT_W   = 16;

endpackage : serial_pattern_detector_pkg

// File: rtl/serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// serial_pattern_detector
// Shifts valid serial RX bits into a PAT_W-bit register and pulses o_hit for
// one cycle, one cycle after the bit that completes PATTERN. A fill counter
// blocks matches until PAT_W fresh bits have arrived since reset/restart.
//
// Parameters
//   PAT_W    : pattern length, 2..32
//   PATTERN  : target sequence, low PAT_W bits used, MSB received first
// Ports
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset (wins over i_bit_valid)
//   i_bit        : serial data bit
//   i_bit_valid  : i_bit is sampled only when high
//   o_hit        : registered one-cycle match pulse
//   o_armed      : registered, high when at least PAT_W-1 bits are held
//
// Build option
//   DETECT_OVERLAP_EN : when defined, fill stays saturated after a hit so
//                       overlapping matches are reported; otherwise a hit
//                       clears fill and the next match needs PAT_W new bits.
// -----------------------------------------------------------------------------
module serial_pattern_detector
   import serial_pattern_detector_pkg::*;
#(
   parameter int unsigned PAT_W   = DEF_PAT_W,
   parameter logic [31:0] PATTERN = DEF_PATTERN
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_bit,
   input  logic i_bit_valid,
   output logic o_hit,
   output logic o_armed
);

   localparam int unsigned      FILL_W   = $clog2(PAT_W + 1);
   localparam logic [PAT_W-1:0] PAT      = PATTERN[PAT_W-1:0];
   localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  sr_q, sr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              hit_q, hit_d;
   logic              armed_q, armed_d;
   logic [PAT_W-1:0]  shifted;
   logic              match;

   always_comb begin
      sr_d    = sr_q;
      fill_d  = fill_q;
      hit_d   = 1'b0;
      shifted = {sr_q[PAT_W-2:0], i_bit};
      // fill_q >= PAT_W-1 means the incoming bit makes a full, fresh window
      match   = i_bit_valid && (shifted == PAT) && (fill_q >= FILL_ARM);

      if (i_bit_valid) begin
         sr_d   = shifted;
         fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      end

      if (match) begin
         hit_d = 1'b1;
`ifdef DETECT_OVERLAP_EN
         fill_d = FILL_MAX;
`else
         fill_d = '0;
`endif
      end

      // armed follows the fill value that will be held next cycle
      armed_d = (fill_d >= FILL_ARM);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sr_q    <= '0;
         fill_q  <= '0;
         hit_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         fill_q  <= fill_d;
         hit_q   <= hit_d;
         armed_q <= armed_d;
      end
   end

   assign o_hit   = hit_q;
   assign o_armed = armed_q;

endmodule : serial_pattern_detector

// File: tb/tb_serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_detector
// Two detector instances: the default 16-bit "HB" detector and a 4-bit 1010
// detector for the overlap behaviour. Each cycle the bench drives both, steps
// a behavioural model, queues the expected {hit, armed} and compares it with
// the DUT outputs one edge later.
// -----------------------------------------------------------------------------
module tb_serial_pattern_detector;
   import serial_pattern_detector_pkg::*;

`ifdef DETECT_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   localparam logic [15:0] PAT16 = 16'h4842;
   localparam logic [3:0]  PAT4  = 4'b1010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst16 = 1'b1, v16 = 1'b0, b16 = 1'b0;
   logic rst4  = 1'b1, v4  = 1'b0, b4  = 1'b0;
   logic hit16, armed16, hit4, armed4;

   serial_pattern_detector u_dut16 (
      .i_clk(clk), .i_rst(rst16), .i_bit(b16), .i_bit_valid(v16),
      .o_hit(hit16), .o_armed(armed16)
   );

   serial_pattern_detector #(.PAT_W(4), .PATTERN(32'h0000_000A)) u_dut4 (
      .i_clk(clk), .i_rst(rst4), .i_bit(b4), .i_bit_valid(v4),
      .o_hit(hit4), .o_armed(armed4)
   );

   typedef struct packed { logic hit; logic armed; } exp_t;
   exp_t q16[$];
   exp_t q4[$];

   int errors = 0;
   int checks = 0;
   logic [HIT_CNT_W-1:0] hit_cnt16 = '0;
   logic [HIT_CNT_W-1:0] hit_cnt4  = '0;
   string phase = "reset";

   logic [31:0] m16_hist = '0;
   int          m16_fill = 0;
   logic [31:0] m4_hist  = '0;
   int          m4_fill  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Behavioural model: history of received bits plus count of fresh bits.
   task automatic model(input int w, input logic [31:0] pat,
                        input logic r, input logic v, input logic b,
                        inout logic [31:0] hist, inout int fill,
                        output exp_t e);
      logic [31:0] mask;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      e.hit = 1'b0;
      if (r) begin
         hist = '0;
         fill = 0;
      end else if (v) begin
         hist = {hist[30:0], b};
         fill = (fill + 1 > w) ? w : fill + 1;
         if (fill == w && (hist & mask) == (pat & mask)) begin
            e.hit = 1'b1;
            if (!OVL) fill = 0;
         end
      end
      e.armed = (fill >= w - 1);
   endtask

   task automatic step(input logic r16_i, input logic v16_i, input logic b16_i,
                       input logic r4_i,  input logic v4_i,  input logic b4_i);
      exp_t e, got;
      rst16 = r16_i; v16 = v16_i; b16 = b16_i;
      rst4  = r4_i;  v4  = v4_i;  b4  = b4_i;
      model(16, {16'h0, PAT16}, r16_i, v16_i, b16_i, m16_hist, m16_fill, e);
      q16.push_back(e);
      model(4, {28'h0, PAT4}, r4_i, v4_i, b4_i, m4_hist, m4_fill, e);
      q4.push_back(e);
      @(posedge clk);
      #1;
      got = q16.pop_front();
      check({phase, "_hit16"},   {31'h0, hit16},   {31'h0, got.hit});
      check({phase, "_armed16"}, {31'h0, armed16}, {31'h0, got.armed});
      got = q4.pop_front();
      check({phase, "_hit4"},    {31'h0, hit4},    {31'h0, got.hit});
      check({phase, "_armed4"},  {31'h0, armed4},  {31'h0, got.armed});
      if (hit16) hit_cnt16 = hit_cnt16 + 1'b1;
      if (hit4)  hit_cnt4  = hit_cnt4 + 1'b1;
   endtask

   task automatic s16(input logic r, input logic v, input logic b);
      step(r, v, b, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [15:0] p;
      logic        rb;
      p = PAT16;

      // Reset with valid bits present: reset must win.
      phase = "reset";
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, p[15-i], 1'b1, 1'b1, 1'b1);
      check("reset_hit16", {31'h0, hit16}, 32'd0);
      check("reset_armed16", {31'h0, armed16}, 32'd0);

      // Fill: 15 bits arm, 16th produces one hit one cycle later.
      phase = "fill";
      hit_cnt16 = '0;
      for (int i = 0; i < 15; i++) s16(1'b0, 1'b1, p[15-i]);
      check("fill_armed_after15", {31'h0, armed16}, 32'd1);
      check("fill_nohit_after15", {31'h0, hit16}, 32'd0);
      s16(1'b0, 1'b1, p[0]);
      check("fill_hit_after16", {31'h0, hit16}, 32'd1);
      idle(3);
      check("fill_hit_count", 32'(hit_cnt16), 32'd1);
      s16(1'b1, 1'b0, 1'b0);

      // Valid gaps: 3 idle cycles between every bit.
      phase = "gaps";
      hit_cnt16 = '0;
      for (int i = 0; i < 16; i++) begin
         s16(1'b0, 1'b1, p[15-i]);
         if (i == 15) check("gaps_hit_after_last", {31'h0, hit16}, 32'd1);
         if (i != 15) idle(3);
      end
      idle(3);
      check("gaps_hit_count", 32'(hit_cnt16), 32'd1);
      s16(1'b1, 1'b0, 1'b0);

      // Reset mid-pattern discards the partial match.
      phase = "midrst";
      hit_cnt16 = '0;
      for (int i = 0; i < 10; i++) s16(1'b0, 1'b1, p[15-i]);
      s16(1'b1, 1'b0, 1'b0);
      for (int i = 10; i < 16; i++) s16(1'b0, 1'b1, p[15-i]);
      idle(2);
      check("midrst_no_hit", 32'(hit_cnt16), 32'd0);
      check("midrst_armed", {31'h0, armed16}, 32'd0);
      for (int i = 0; i < 16; i++) s16(1'b0, 1'b1, p[15-i]);
      idle(2);
      check("midrst_full_hit", 32'(hit_cnt16), 32'd1);
      s16(1'b1, 1'b0, 1'b0);

      // Random non-matching stream.
      phase = "random";
      hit_cnt16 = '0;
      for (int i = 0; i < 64; i++) begin
         rb = 1'($urandom_range(0, 1));
         if ({m16_hist[14:0], rb} == PAT16) rb = ~rb;
         s16(1'b0, 1'b1, rb);
      end
      idle(2);
      check("random_hit_count", 32'(hit_cnt16), 32'd0);

      // Overlap behaviour on the 4-bit detector: stream 1,0,1,0,1,0,1.
      phase = "overlap";
      hit_cnt4 = '0;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (i % 2 == 0));
         if (i == 3) begin
            check("overlap_hit_bit4", {31'h0, hit4}, 32'd1);
            check("overlap_armed_bit4", {31'h0, armed4}, {31'h0, OVL});
         end
         if (i == 5) check("overlap_hit_bit6", {31'h0, hit4}, {31'h0, OVL});
      end
      idle(2);
      check("overlap_hit_count", 32'(hit_cnt4), OVL ? 32'd2 : 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_pattern_detector
